// File: rtl/vga_pkg.sv
// vga_pkg: shared op/state encodings, default resolution and clog2 helper
//   OP_TILE/OP_CLEAR : request opcodes
//   state_t          : plotter FSM states
//   DEF_W/DEF_H      : default screen resolution
//   clog2            : ceiling log2 for elaboration-time sizing
package vga_pkg;
  localparam logic OP_TILE = 1'b0;
  localparam logic OP_CLEAR = 1'b1;
  localparam int DEF_W = 160;
  localparam int DEF_H = 120;
  typedef enum logic [1:0] {IDLE, TILE_RUN, CLEAR_RUN} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/vga_tile_plotter_raster_counter.sv
// raster_counter: 2-D raster position counter, x fastest, bounded by XMAX/YMAX
//   clk, resetn : clock, async active-low reset
//   clr         : synchronous return to (0,0)
//   en          : advance one position
//   nx, ny      : position the counter moves to on the next enable
//   last        : current position is (XMAX,YMAX)
//   nlast       : next position is (XMAX,YMAX)
module raster_counter #(
  parameter int XW = 2,
  parameter int YW = 2,
  parameter int XMAX = 3,
  parameter int YMAX = 3
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          clr,
  input  logic          en,
  output logic [XW-1:0] nx,
  output logic [YW-1:0] ny,
  output logic          last,
  output logic          nlast
);
  logic [XW-1:0] cx;
  logic [YW-1:0] cy;
  logic wrap;
  // compare against explicit limits so a counter wider than the screen never runs past it
  always_comb begin
    wrap = cx == XW'(XMAX);
    nx = wrap ? '0 : cx + 1'b1;
    ny = wrap ? (cy == YW'(YMAX) ? '0 : cy + 1'b1) : cy;
    last = wrap && cy == YW'(YMAX);
    nlast = nx == XW'(XMAX) && ny == YW'(YMAX);
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      cx <= '0;
      cy <= '0;
    end else if (clr) begin
      cx <= '0;
      cy <= '0;
    end else if (en) begin
      cx <= nx;
      cy <= ny;
    end
endmodule

// File: rtl/vga_tile_plotter.sv
// vga_tile_plotter: streams one pixel write per clock for tile fills and full-screen clears
//   clk, resetn         : clock, async active-low reset
//   req_valid/req_ready : request handshake, ready only while idle
//   req_op              : OP_TILE fills one tile, OP_CLEAR fills the screen
//   req_col, req_row    : tile index (ignored for clear)
//   req_colour          : fill colour
//   x, y, colour, plot  : registered pixel write to the adapter
//   done                : pulses with the last pixel of an operation
//   err                 : pulses the cycle after an out-of-range tile request
module vga_tile_plotter
  import vga_pkg::*;
#(
  parameter int SCREEN_W = DEF_W,
  parameter int SCREEN_H = DEF_H,
  parameter int X_W = 8,
  parameter int Y_W = 7,
  parameter int TILE = 4,
  parameter int COLOUR_W = 3
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_op,
  input  logic [X_W-1:0]      req_col,
  input  logic [Y_W-1:0]      req_row,
  input  logic [COLOUR_W-1:0] req_colour,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                done,
  output logic                err
);
  localparam int TS = clog2(TILE);
  localparam int NCOL = SCREEN_W / TILE;
  localparam int NROW = SCREEN_H / TILE;
  state_t state, state_n;
  logic [X_W-1:0] base_x, base_x_n, x_n, ncx;
  logic [Y_W-1:0] base_y, base_y_n, y_n, ncy;
  logic [COLOUR_W-1:0] colour_n;
  logic [TS-1:0] ndx, ndy;
  logic plot_n, done_n, err_n, clr, t_en, c_en, in_range;
  logic t_last, t_nlast, c_last, c_nlast;
  raster_counter #(.XW(TS), .YW(TS), .XMAX(TILE - 1), .YMAX(TILE - 1)) u_tile (
    .clk(clk), .resetn(resetn), .clr(clr), .en(t_en),
    .nx(ndx), .ny(ndy), .last(t_last), .nlast(t_nlast)
  );
  raster_counter #(.XW(X_W), .YW(Y_W), .XMAX(SCREEN_W - 1), .YMAX(SCREEN_H - 1)) u_screen (
    .clk(clk), .resetn(resetn), .clr(clr), .en(c_en),
    .nx(ncx), .ny(ncy), .last(c_last), .nlast(c_nlast)
  );
  assign req_ready = state == IDLE;
  assign in_range = {1'b0, req_col} < (X_W + 1)'(NCOL) && {1'b0, req_row} < (Y_W + 1)'(NROW);
  // counters hold the index of the pixel currently on the outputs; the pixel for the
  // next cycle is taken from their look-ahead so x/y/done can stay registered
  always_comb begin
    state_n = state;
    base_x_n = base_x;
    base_y_n = base_y;
    x_n = x;
    y_n = y;
    colour_n = colour;
    plot_n = 1'b0;
    done_n = 1'b0;
    err_n = 1'b0;
    clr = 1'b0;
    t_en = 1'b0;
    c_en = 1'b0;
    case (state)
      IDLE:
        if (req_valid) begin
          if (req_op == OP_CLEAR) begin
            state_n = CLEAR_RUN;
            clr = 1'b1;
            colour_n = req_colour;
            x_n = '0;
            y_n = '0;
            plot_n = 1'b1;
          end else if (in_range) begin
            state_n = TILE_RUN;
            clr = 1'b1;
            colour_n = req_colour;
            base_x_n = req_col << TS;
            base_y_n = req_row << TS;
            x_n = base_x_n;
            y_n = base_y_n;
            plot_n = 1'b1;
          end else
            err_n = 1'b1;
        end
      TILE_RUN:
        if (t_last)
          state_n = IDLE;
        else begin
          t_en = 1'b1;
          plot_n = 1'b1;
          done_n = t_nlast;
          x_n = base_x + X_W'(ndx);
          y_n = base_y + Y_W'(ndy);
        end
      CLEAR_RUN:
        if (c_last)
          state_n = IDLE;
        else begin
          c_en = 1'b1;
          plot_n = 1'b1;
          done_n = c_nlast;
          x_n = ncx;
          y_n = ncy;
        end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn)
      state <= IDLE;
    else
      state <= state_n;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      base_x <= '0;
      base_y <= '0;
      x <= '0;
      y <= '0;
      colour <= '0;
      plot <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      base_x <= base_x_n;
      base_y <= base_y_n;
      x <= x_n;
      y <= y_n;
      colour <= colour_n;
      plot <= plot_n;
      done <= done_n;
      err <= err_n;
    end
endmodule

// File: doc/vga_tile_plotter.md
Name: vga_tile_plotter

Overview:
Parametrised pixel-write engine between game logic and vga_adapter. It accepts tile-draw and clear-screen requests over a valid/ready handshake and streams one pixel write per clock (x, y, colour, plot) into the adapter. It generalises the fixed 160x120 single-pixel plot path to any resolution, tile size and colour depth, and adds a full-screen clear mode.

Parameters:
SCREEN_W, 160, horizontal resolution in pixels
SCREEN_H, 120, vertical resolution in pixels
X_W, 8, x coordinate width; must satisfy 2^X_W >= SCREEN_W
Y_W, 7, y coordinate width; must satisfy 2^Y_W >= SCREEN_H
TILE, 4, tile edge in pixels; power of two; must divide SCREEN_W and SCREEN_H
COLOUR_W, 3, colour width; 3 matches the adapter's 1 bit per channel

Ports:
clk  in  1  system clock (CLOCK_50 at top)
resetn  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  engine idle; request accepted on req_valid & req_ready at a rising edge
req_op  in  1  0 = fill tile, 1 = clear screen
req_col  in  X_W  tile column index (ignored for clear)
req_row  in  Y_W  tile row index (ignored for clear)
req_colour  in  COLOUR_W  fill colour
x  out  X_W  pixel x to adapter
y  out  Y_W  pixel y to adapter
colour  out  COLOUR_W  pixel colour to adapter
plot  out  1  write strobe to adapter
done  out  1  one-cycle pulse marking the last pixel of an operation
err  out  1  one-cycle pulse when a request is rejected

Behaviour:
- Reset (asynchronous, resetn=0): state=IDLE, x=0, y=0, colour=0, plot=0, done=0, err=0. req_ready=1 once resetn=1.
- Localparams: TS=log2(TILE), NCOL=SCREEN_W/TILE, NROW=SCREEN_H/TILE.
- States: IDLE, TILE_RUN, CLEAR_RUN. req_ready=1 only in IDLE.
- IDLE accept, op=0, req_col<NCOL and req_row<NROW:
  - latch base_x = req_col<<TS, base_y = req_row<<TS and the colour.
  - Go to TILE_RUN.
- IDLE accept, op=0, tile out of range:
  - err=1 for the following cycle. No plot. Stay in IDLE.
- IDLE accept, op=1: latch the colour and go to CLEAR_RUN. Row/column values are never checked.
- All outputs are registered.
  - First pixel appears the cycle after acceptance, with plot=1.
  - plot stays high every cycle until the operation ends. No gaps.
- TILE_RUN order: raster within the tile, x fastest.
  - x = base_x+dx, y = base_y+dy, with dx and dy from 0 to TILE-1.
  - Exactly TILE*TILE plots.
- CLEAR_RUN order: x from 0 to SCREEN_W-1 fastest, y from 0 to SCREEN_H-1.
  - Exactly SCREEN_W*SCREEN_H plots.
- done=1 in the same cycle as the last plot. The next cycle has plot=0, done=0, state=IDLE and req_ready=1.
  - Back-to-back requests therefore have a minimum gap of one idle cycle between pixel streams.
- req_valid while busy: ignored, with no side effects. Request fields may change freely while req_ready=0.
- Counter arithmetic: dx and dy are TS bits wide. The clear counters are X_W and Y_W bits wide and compare against SCREEN_W-1 and SCREEN_H-1.
  - Counters never wrap past the screen bound, even when 2^X_W > SCREEN_W.
- resetn deasserted mid-operation: the operation is aborted immediately.
  - plot=0 asynchronously. Pixels already written are not undone.
  - No done pulse for the aborted operation.
- x, y and colour hold their last values when plot=0.

Decomposition:
- Shared package/header vga_pkg: op encodings (OP_TILE=0, OP_CLEAR=1), state encodings, default resolution constants (160, 120) and the clog2 helper.
- One sub-module, raster_counter: parametrised width and limit pair, with enable, last flag and synchronous clear.
  - Instantiated once for tile (dx, dy) and once for screen (cx, cy). Alternatively, a single instance with a muxed limit.

Test Plan:
- Reset then tile draw, defaults: op=0, col=3, row=2, colour=3'b100.
  - 16 consecutive plots, x=12..15 inner, y=8..11 outer, colour=4.
  - done with the 16th plot; req_ready=1 on the following cycle.
- Clear: op=1, colour=0.
  - 19200 consecutive plots; first (0,0), last (159,119).
  - done on the last plot; no x>=160 or y>=120 ever seen.
- Out of range: op=0, col=40, row=0.
  - err pulse one cycle after acceptance; plot never asserts; req_ready stays 1.
- Busy ignore: during a tile run, hold req_valid=1 with col=0, row=0.
  - Accepted only at the first req_ready=1 edge; its first plot follows one idle gap cycle.
  - Total 32 plots for the two requests.
- Reset mid-clear: drop resetn for 2 cycles at plot #500.
  - plot=0 immediately; no done pulse; after release req_ready=1 and all outputs 0.
- Parameter sweep: SCREEN_W=320, SCREEN_H=240, X_W=9, Y_W=8, TILE=8, COLOUR_W=9; tile col=39, row=29.
  - 64 plots covering x=312..319, y=232..239.
